// File: rtl/serial_link_pkg.sv
// serial_link_pkg: shared state encoding and word width for the PISO/SIPO serial link
package serial_link_pkg;
  localparam int DEF_WIDTH = 4;
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_SHIFT = 1'b1;
  typedef enum logic {IDLE = ST_IDLE, SHIFT = ST_SHIFT} state_t;
endpackage

// File: rtl/sipo_deser_if.sv
// sipo_deser_if: serial input and parallel valid/ready output bundle of the deserializer
interface sipo_deser_if import serial_link_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
  logic sin_valid;
  logic sin;
  logic frame_start;
  logic [WIDTH-1:0] dout;
  logic dout_valid;
  logic dout_ready;
  logic overrun;
  logic clr_ovr;
  modport master(output sin_valid, sin, frame_start, dout_ready, clr_ovr, input dout, dout_valid, overrun);
  modport slave(input sin_valid, sin, frame_start, dout_ready, clr_ovr, output dout, dout_valid, overrun);
endinterface

// File: rtl/sipo_bit_cnt.sv
// sipo_bit_cnt: frame bit counter with load-1, increment, clear and last-bit flag
module sipo_bit_cnt import serial_link_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load1,
  input  logic          incr,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          last
);
  assign last = cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (load1) cnt <= CW'(1);
    else if (clr) cnt <= '0;
    else if (incr) cnt <= cnt + 1'b1;
endmodule

// File: rtl/sipo_deser.sv
// sipo_deser: framed serial-in/parallel-out deserializer with one-word hold and sticky overrun
module sipo_deser import serial_link_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic        clk,
  input logic        rst,
  sipo_deser_if.slave bus
);
  state_t state, state_n;
  logic load1, incr, done, last;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [$clog2(WIDTH)-1:0] cnt;
  sipo_bit_cnt #(.WIDTH(WIDTH)) u_cnt (
    .clk(clk), .rst(rst), .load1(load1), .incr(incr), .clr(done), .cnt(cnt), .last(last)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    load1 = bus.sin_valid && bus.frame_start;
    incr = bus.sin_valid && !bus.frame_start && state == SHIFT && !last;
    done = bus.sin_valid && !bus.frame_start && state == SHIFT && last;
    state_n = load1 ? SHIFT : done ? IDLE : state;
  end
  // a frame start always restarts from a clean register, so a discarded partial frame leaves no residue
  always_comb
    shreg_n = load1 ? (MSB_FIRST ? {{(WIDTH-1){1'b0}}, bus.sin} : {bus.sin, {(WIDTH-1){1'b0}}})
                    : (MSB_FIRST ? {shreg[WIDTH-2:0], bus.sin} : {bus.sin, shreg[WIDTH-1:1]});
  always_ff @(posedge clk or posedge rst)
    if (rst) shreg <= '0;
    else if (load1 || incr || done) shreg <= shreg_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.dout <= '0;
      bus.dout_valid <= 1'b0;
      bus.overrun <= 1'b0;
    end else begin
      if (done && (!bus.dout_valid || bus.dout_ready)) begin
        bus.dout <= shreg_n;
        bus.dout_valid <= 1'b1;
      end else if (bus.dout_valid && bus.dout_ready) bus.dout_valid <= 1'b0;
      if (done && bus.dout_valid && !bus.dout_ready) bus.overrun <= 1'b1;
      else if (bus.clr_ovr) bus.overrun <= 1'b0;
    end
endmodule
